// File: rtl/sm4_cipher_core.sv
// Iterative SM4 block cipher: 32-cycle key expansion into an internal round-key file, then one round per clock.
// Optional SM4_BUSY_EN macro adds a busy output that is high while a key expansion or block is in progress.
module sm4_cipher_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_key_exps,
    input  logic         en_sm4,
    input  logic         encdec,
    input  logic [127:0] key,
    input  logic         key_valid,
    output logic         key_exps_done,
    input  logic [127:0] bdi,
    input  logic         bdi_valid,
    output logic [127:0] bdo,
    output logic         bdo_valid
`ifdef SM4_BUSY_EN
    ,
    output logic         busy
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_KEYEXP = 2'd1;
    localparam logic [1:0] ST_CRYPT  = 2'd2;

    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            r[31-8*j -: 8] = 8'(((32'(i) << 2) + 32'(j)) * 32'd7);
        end
        return r;
    endfunction

    function automatic logic [31:0] l_round(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    logic [1:0]   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         edge_q, edge_d;
    logic         done_q, done_d;
    logic         vld_q, vld_d;
    logic [127:0] bdo_q, bdo_d;
    logic         dec_q, dec_d;
    logic [127:0] w_q, w_d;
    logic [31:0]  rk_q [32];

    logic         kx_req, kx_start, accept, rk_we;
    logic [31:0]  rk_sel, mix, sb, new_word;

    // Shared datapath: the window word X(i)/K(i) is combined with T or T' of the other three.
    always_comb begin
        kx_req   = en_key_exps & key_valid;
        kx_start = en_sm4 && (state_q == ST_IDLE) && kx_req && !edge_q;
        accept   = en_sm4 && (state_q == ST_IDLE) && done_q && bdi_valid && !kx_start;
        rk_sel   = rk_q[dec_q ? ~cnt_q : cnt_q];
        mix      = w_q[95:64] ^ w_q[63:32] ^ w_q[31:0]
                 ^ ((state_q == ST_KEYEXP) ? ck_word(cnt_q) : rk_sel);
        sb       = {SBOX[mix[31:24]], SBOX[mix[23:16]], SBOX[mix[15:8]], SBOX[mix[7:0]]};
        new_word = w_q[127:96] ^ ((state_q == ST_KEYEXP) ? l_key(sb) : l_round(sb));

        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        done_d  = done_q;
        bdo_d   = bdo_q;
        dec_d   = dec_q;
        w_d     = w_q;
        vld_d   = 1'b0;
        rk_we   = 1'b0;

        if (en_sm4) begin
            edge_d = kx_req;
            case (state_q)
                ST_IDLE: begin
                    if (kx_start) begin
                        w_d     = key ^ FK;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        state_d = ST_KEYEXP;
                    end else if (accept) begin
                        w_d     = bdi;
                        dec_d   = encdec;
                        cnt_d   = '0;
                        state_d = ST_CRYPT;
                    end
                end
                ST_KEYEXP: begin
                    rk_we = 1'b1;
                    w_d   = {w_q[95:0], new_word};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_CRYPT: begin
                    w_d   = {w_q[95:0], new_word};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        bdo_d   = {new_word, w_q[31:0], w_q[63:32], w_q[95:64]};
                        vld_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            edge_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            bdo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            bdo_q   <= bdo_d;
        end
    end

    always_ff @(posedge clk) begin
        w_q   <= w_d;
        dec_q <= dec_d;
        if (rk_we) rk_q[cnt_q] <= new_word;
    end

    assign key_exps_done = done_q;
    assign bdo           = bdo_q;
    assign bdo_valid     = vld_q;
`ifdef SM4_BUSY_EN
    assign busy          = (state_q != ST_IDLE);
`endif

endmodule

// File: tb/tb_sm4_cipher_core.sv
// Directed bench for sm4_cipher_core using the GB/T 32907 example vector.
module tb_sm4_cipher_core;

    logic         clk = 1'b0;
    logic         rst, en_key_exps, en_sm4, encdec, key_valid, bdi_valid;
    logic [127:0] key, bdi;
    logic         key_exps_done, bdo_valid;
    logic [127:0] bdo;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

    sm4_cipher_core dut (
        .clk(clk), .rst(rst), .en_key_exps(en_key_exps), .en_sm4(en_sm4),
        .encdec(encdec), .key(key), .key_valid(key_valid),
        .key_exps_done(key_exps_done), .bdi(bdi), .bdi_valid(bdi_valid),
        .bdo(bdo), .bdo_valid(bdo_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_vld(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bdo_valid && n < max);
    endtask

    initial begin
        int n, m;
        logic seen;
        rst = 1'b1; en_key_exps = 1'b0; en_sm4 = 1'b1; encdec = 1'b0;
        key_valid = 1'b0; bdi_valid = 1'b0; key = '0; bdi = '0;
        step(); step();
        chk("rst_bdo", bdo, '0);
        chk("rst_bdo_valid", 128'(bdo_valid), 128'd0);
        chk("rst_done", 128'(key_exps_done), 128'd0);
        rst = 1'b0;

        // Block offered before any key: must be ignored
        bdi = PT; bdi_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); seen |= bdo_valid; end
        chk("prekey_no_valid", 128'(seen), 128'd0);
        bdi_valid = 1'b0;

        // Key expansion
        key = PT; en_key_exps = 1'b1; key_valid = 1'b1;
        step();
        n = 0;
        do begin step(); n++; end while (!key_exps_done && n < 40);
        chk("keyexp_latency", 128'(n), 128'd32);
        step(); step(); step();
        chk("done_held_no_restart", 128'(key_exps_done), 128'd1);
        en_key_exps = 1'b0;

        // Encrypt
        bdi = PT; encdec = 1'b0; bdi_valid = 1'b1;
        step();
        bdi_valid = 1'b0;
        wait_vld(40, n);
        chk("enc_latency", 128'(n), 128'd32);
        chk("enc_bdo", bdo, CT);
        step();
        chk("enc_pulse_one_cycle", 128'(bdo_valid), 128'd0);
        chk("enc_bdo_hold", bdo, CT);

        // Decrypt
        bdi = CT; encdec = 1'b1; bdi_valid = 1'b1;
        step();
        bdi_valid = 1'b0;
        wait_vld(40, n);
        chk("dec_latency", 128'(n), 128'd32);
        chk("dec_bdo", bdo, PT);

        // Back-to-back: encrypt then decrypt with bdi_valid held high
        bdi = PT; encdec = 1'b0; bdi_valid = 1'b1;
        step();
        wait_vld(40, n);
        chk("b2b_first_latency", 128'(n), 128'd32);
        chk("b2b_first_bdo", bdo, CT);
        bdi = CT; encdec = 1'b1;
        wait_vld(40, n);
        bdi_valid = 1'b0;
        chk("b2b_spacing", 128'(n), 128'd33);
        chk("b2b_second_bdo", bdo, PT);

        // en_sm4 dropped for 5 cycles mid-CRYPT
        step();
        bdi = PT; encdec = 1'b0; bdi_valid = 1'b1;
        step();
        bdi_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); seen |= bdo_valid; end
        en_sm4 = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); seen |= bdo_valid; end
        en_sm4 = 1'b1;
        wait_vld(40, m);
        chk("stall_latency", 128'(15 + m), 128'd37);
        chk("stall_bdo", bdo, CT);
        chk("stall_no_early_valid", 128'(seen), 128'd0);

        // Reset mid-CRYPT
        step();
        bdi = CT; encdec = 1'b1; bdi_valid = 1'b1;
        step();
        bdi_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_bdo", bdo, '0);
        chk("abort_bdo_valid", 128'(bdo_valid), 128'd0);
        chk("abort_done", 128'(key_exps_done), 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin step(); seen |= bdo_valid; end
        chk("abort_no_late_pulse", 128'(seen), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm4_cipher_core.md
Name: sm4_cipher_core

Overview:
- Iterative SM4 (GB/T 32907) 128-bit block cipher core, one round per clock.
- Expands a 128-bit key into 32 round keys and stores them internally.
- Then encrypts or decrypts 128-bit blocks using the stored round keys.
- Sits between a host/bus wrapper supplying key and data and downstream logic consuming bdo.

Parameters:
- None. Block size, key size and round count are fixed by the SM4 standard.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_key_exps  in  1  key-expansion request enable.
- en_sm4  in  1  core enable; when low, all state is frozen.
- encdec  in  1  0 = encrypt, 1 = decrypt; sampled when a block is accepted.
- key  in  128  cipher key MK0..MK3, MK0 in bits [127:96].
- key_valid  in  1  key bus holds a valid key.
- key_exps_done  out  1  round-key file valid (level).
- bdi  in  128  input block X0..X3, X0 in bits [127:96].
- bdi_valid  in  1  input block valid.
- bdo  out  128  output block.
- bdo_valid  out  1  one-cycle pulse; bdo is valid in that cycle.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, round counter 0, edge-detect register 0. The round-key file is not cleared, but it is unusable because key_exps_done=0.
- en_sm4=0: no state changes at all; counters and registers hold; bdo_valid is held low.
- FSM has three states:
  - IDLE
  - KEYEXP: 32 cycles.
  - CRYPT: 32 cycles.
- Key-expansion start condition: state IDLE, en_sm4=1, and a rising edge of (en_key_exps & key_valid). The rising edge is detected against a registered copy of that AND.
  - On start: K0..K3 = key XOR FK; FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - On start: key_exps_done is cleared.
  - Holding en_key_exps high does not restart expansion. Re-keying requires deasserting, then reasserting, en_key_exps&key_valid.
- KEYEXP, cycle i=0..31:
  - rk[i] = K(i) XOR T'(K(i+1)^K(i+2)^K(i+3)^CK(i)).
  - Shift the K window by one word.
  - CK(i) byte j = (4i+j)*7 mod 256.
  - T' = standard S-box on each byte, then L'(B) = B ^ (B<<<13) ^ (B<<<23).
  - After rk[31] is written: key_exps_done=1 (same edge), return to IDLE.
  - key_exps_done stays high until the next expansion start or reset.
- Block accept condition: state IDLE, en_sm4=1, key_exps_done=1, bdi_valid=1, and no key-expansion start that cycle.
  - Key expansion has priority over block acceptance when both occur in the same cycle.
  - On accept: latch bdi and encdec.
  - bdi_valid while key_exps_done=0 is ignored.
- CRYPT, round i=0..31:
  - X(i+4) = X(i) ^ T(X(i+1)^X(i+2)^X(i+3)^rk).
  - rk = rk[i] when encrypting, rk[31-i] when decrypting.
  - T = S-box on each byte, then L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24).
- Output: on the edge of round 31, bdo = {X35, X34, X33, X32} (reverse transform R) and bdo_valid=1 for exactly one cycle; FSM returns to IDLE.
  - Latency: bdo_valid is high in the cycle beginning 32 clock edges after the accept edge.
  - bdo holds its value until the next completion or reset.
- Next block may be accepted the cycle bdo_valid is high (IDLE).
- Inputs other than en_sm4 and rst are ignored during KEYEXP and CRYPT.
- rst mid-operation: the operation is aborted immediately and no bdo_valid is produced.
- S-box: 256-entry standard SM4 table, combinational ROM; one instance for rounds, one for key expansion (or shared, muxed by state).

Optional Feature:
- Macro SM4_BUSY_EN.
- When defined, adds output port busy (1 bit): high while FSM is in KEYEXP or CRYPT, 0 at reset.
- When undefined, the port does not exist and behaviour is otherwise identical.

Test Plan:
- Standard vector, encrypt: rst, then key=0123456789abcdeffedcba9876543210, en_key_exps=1, key_valid=1 -> key_exps_done rises 32 cycles after start. Then bdi=0123456789abcdeffedcba9876543210, encdec=0 -> bdo=681edf34d206965e86b3e94f536e4246 with one-cycle bdo_valid 32 cycles after accept.
- Standard vector, decrypt: same key, bdi=681edf34d206965e86b3e94f536e4246, encdec=1 -> bdo=0123456789abcdeffedcba9876543210.
- bdi_valid held high continuously after done -> back-to-back blocks; a bdo_valid pulse every 33 cycles, each output correct.
- bdi_valid asserted before key_exps_done -> no acceptance, no bdo_valid until expansion completes.
- rst asserted at round 10 of CRYPT -> bdo=0, bdo_valid=0, key_exps_done=0 the next cycle; no later output pulse.
- en_sm4 dropped for 5 cycles mid-CRYPT -> result is unchanged, and bdo_valid is delayed exactly 5 cycles.
